// File: rtl/mdr_input_conditioner.sv
// START/LOAD push-button conditioner: sync + debounce, one active-low pulse per press, SYNC_STAGES+DEBOUNCE_CYC edges latency.
// No backpressure (free-running). Optional status outputs under `define MDR_BTN_STATUS_EN.
module mdr_input_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start_n,
  input  logic       i_load_n,
  output logic       o_start_n,
  output logic       o_load_n
`ifdef MDR_BTN_STATUS_EN
  ,
  output logic       o_start_lvl,
  output logic       o_load_lvl,
  output logic [7:0] o_bounce_cnt
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic [1:0] raw;
  logic [1:0] pulse_n;
`ifdef MDR_BTN_STATUS_EN
  logic [1:0] reject;
  logic [1:0] lvl;
`endif

  assign raw = {i_load_n, i_start_n};

  // Channel 0 = START, channel 1 = LOAD; both are identical and independent.
  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pulse_q, pulse_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b1;
      case (state_q)
        ST_RELEASED: begin
          if (!s) begin
            state_d = ST_PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (s) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
            pulse_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (s) begin
            state_d = ST_RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!s) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= ST_RELEASED;
        cnt_q   <= '0;
        pulse_q <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_n[g] = pulse_q;
`ifdef MDR_BTN_STATUS_EN
    assign reject[g] = (state_q == ST_PRESS_WAIT) && s;
    assign lvl[g]    = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);
`endif
  end

  assign o_start_n = pulse_n[0];
  assign o_load_n  = pulse_n[1];

`ifdef MDR_BTN_STATUS_EN
  logic [7:0] bounce_q;
  logic [8:0] bounce_sum;

  assign bounce_sum = {1'b0, bounce_q} + 9'(reject[0]) + 9'(reject[1]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bounce_q <= '0;
    end else begin
      bounce_q <= bounce_sum[8] ? 8'hff : bounce_sum[7:0];
    end
  end

  assign o_start_lvl  = lvl[0];
  assign o_load_lvl   = lvl[1];
  assign o_bounce_cnt = bounce_q;
`endif

endmodule

// File: tb/tb_mdr_input_conditioner.sv
// Directed bench for mdr_input_conditioner with DEBOUNCE_CYC=4, SYNC_STAGES=2 (pulse after edge 6).
module tb_mdr_input_conditioner;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start_n = 1'b1;
  logic i_load_n = 1'b1;
  logic o_start_n, o_load_n;
`ifdef MDR_BTN_STATUS_EN
  logic       o_start_lvl, o_load_lvl;
  logic [7:0] o_bounce_cnt;
  int         exp_bounce;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdr_input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_start_n (i_start_n),
    .i_load_n  (i_load_n),
    .o_start_n (o_start_n),
    .o_load_n  (o_load_n)
`ifdef MDR_BTN_STATUS_EN
    ,
    .o_start_lvl  (o_start_lvl),
    .o_load_lvl   (o_load_lvl),
    .o_bounce_cnt (o_bounce_cnt)
`endif
  );

  typedef struct {
    string name;
    int    s_lo, s_len, l_lo, l_len;
    int    s_cnt, s_first, l_cnt, l_first;
    int    rej;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] press(input int lo, input int len);
    logic [127:0] p;
    p = '1;
    for (int k = 0; k < 128; k++)
      if (k >= lo && k < lo + len) p[k] = 1'b0;
    return p;
  endfunction

  // Starts and ends at a falling edge; cycle k's input is first sampled at rising edge k.
  task automatic run_pat(input logic [127:0] sp, input logic [127:0] lp, input int n,
                         output int sc, output int sf, output int lc, output int lf);
    sc = 0; sf = -1; lc = 0; lf = -1;
    for (int k = 0; k < n; k++) begin
      i_start_n = sp[k];
      i_load_n  = lp[k];
      @(posedge clk);
      @(negedge clk);
      if (o_start_n === 1'b0) begin sc++; if (sf < 0) sf = k; end
      if (o_load_n === 1'b0) begin lc++; if (lf < 0) lf = k; end
    end
    i_start_n = 1'b1;
    i_load_n  = 1'b1;
  endtask

  initial begin
    int sc, sf, lc, lf, first;

    vecs[0] = '{"clean_start",  0, 20, 0,  0, 1,  6, 0, -1, 0};
    vecs[1] = '{"short_start",  0,  4, 0,  0, 0, -1, 0, -1, 1};
    vecs[2] = '{"min_start",    0,  5, 0,  0, 1,  6, 0, -1, 0};
    vecs[3] = '{"simultaneous", 0, 20, 0, 20, 1,  6, 1,  6, 0};
    vecs[4] = '{"load_offset",  0,  0, 3, 10, 0, -1, 1,  9, 0};
    vecs[5] = '{"staggered",    2,  8, 5,  8, 1,  8, 1, 11, 0};
    vecs[6] = '{"short_load",   0,  0, 0,  4, 0, -1, 0, -1, 1};

    repeat (3) @(negedge clk);
    check("reset_start", int'(o_start_n), 1);
    check("reset_load", int'(o_load_n), 1);
`ifdef MDR_BTN_STATUS_EN
    check("reset_start_lvl", int'(o_start_lvl), 0);
    check("reset_load_lvl", int'(o_load_lvl), 0);
    check("reset_bounce", int'(o_bounce_cnt), 0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Load bounce: low 3, high 1, low 3, then released.
    run_pat('1, press(0, 3) & press(4, 3), 30, sc, sf, lc, lf);
    check("bounce_load_cnt", lc, 0);
    check("bounce_start_cnt", sc, 0);
`ifdef MDR_BTN_STATUS_EN
    check("bounce_count", int'(o_bounce_cnt), 2);
    exp_bounce = 2;
`endif

    for (int i = 0; i < 7; i++) begin
      run_pat(press(vecs[i].s_lo, vecs[i].s_len), press(vecs[i].l_lo, vecs[i].l_len), 40,
              sc, sf, lc, lf);
      check($sformatf("%s_start_cnt", vecs[i].name), sc, vecs[i].s_cnt);
      check($sformatf("%s_start_first", vecs[i].name), sf, vecs[i].s_first);
      check($sformatf("%s_load_cnt", vecs[i].name), lc, vecs[i].l_cnt);
      check($sformatf("%s_load_first", vecs[i].name), lf, vecs[i].l_first);
`ifdef MDR_BTN_STATUS_EN
      exp_bounce += vecs[i].rej;
      check($sformatf("%s_bounce", vecs[i].name), int'(o_bounce_cnt), exp_bounce);
`endif
    end

    // Release glitches while held, then a stable release and a second press.
    run_pat(press(0, 20) & press(22, 2) & press(26, 2) & press(40, 10), '1, 65, sc, sf, lc, lf);
    check("rel_bounce_cnt", sc, 2);
    check("rel_bounce_first", sf, 6);
    check("rel_bounce_load", lc, 0);

    // START, LOAD, LOAD as seen by the control FSM.
    run_pat(press(0, 8), press(20, 8) & press(45, 8), 70, sc, sf, lc, lf);
    check("seq_start_cnt", sc, 1);
    check("seq_start_first", sf, 6);
    check("seq_load_cnt", lc, 2);
    check("seq_load_first", lf, 26);

    // Reset in PRESS_WAIT, then in the pulse cycle, with START held throughout.
    i_start_n = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    #1;
    check("rst_pw_start", int'(o_start_n), 1);
    check("rst_pw_load", int'(o_load_n), 1);
    @(negedge clk);
    rst = 1'b1;
    first = -1;
    for (int k = 0; k < 20 && first < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_start_n === 1'b0) first = k;
    end
    check("rst_held_first", first, 6);
    rst = 1'b0;
    #1;
    check("rst_pulse_clear", int'(o_start_n), 1);
    @(negedge clk);
    rst = 1'b1;
    run_pat(press(0, 20), '1, 35, sc, sf, lc, lf);
    check("rst_again_cnt", sc, 1);
    check("rst_again_first", sf, 6);
`ifdef MDR_BTN_STATUS_EN
    check("rst_bounce", int'(o_bounce_cnt), 0);
    check("end_start_lvl", int'(o_start_lvl), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
